alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one parameter: SETTLE_CYCLES, default 2, the number of clock cycles the ALU operands are held stable before capture (legal range 1..15).
REQ-002 The block SHALL have the following ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a  input  32  requester 0 operand A.
- req0_b  input  32  requester 0 operand B.
- req0_cmd  input  3  requester 0 ALU command.
- req1_valid, req1_ready, req1_a, req1_b, req1_cmd: same directions, widths and meanings as the requester 0 ports, for requester 1.
- rsp_valid  output  1  response held.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  1  requester that issued the response.
- rsp_result  output  32  captured ALU result.
- rsp_carryout  output  1  captured ALU carryout.
- rsp_zero  output  1  captured ALU zero flag.
- rsp_overflow  output  1  captured ALU overflow flag.

Function
REQ-003 The block SHALL share one internal ALU instance between two requesters, one operation in flight at a time.
REQ-004 The FSM SHALL have three states: IDLE, SETTLE and RESP.
- IDLE -> SETTLE on accept.
- SETTLE -> RESP when the counter equals 0.
- RESP -> IDLE on rsp_valid && rsp_ready.
REQ-005 reqN_ready SHALL be combinational and equal (state==IDLE) && rst_n && (grant==N); at most one ready SHALL be high in any cycle.
REQ-006 An accept SHALL occur on a rising edge where reqN_valid && reqN_ready.
REQ-007 On accept, the block SHALL:
- latch a, b and cmd into the operand registers;
- latch N into the id register;
- load the counter with SETTLE_CYCLES-1.
REQ-008 Grant SHALL be round-robin:
- With a single valid requester, that requester is granted.
- With both valid, the requester not equal to last_grant is granted.
- last_grant SHALL update on accept only.
REQ-009 The ALU inputs SHALL be driven only from the operand registers, which SHALL remain constant from the accept edge until the next accept.
REQ-010 In SETTLE, the counter SHALL decrement each edge. At the edge where the counter is 0, the block SHALL capture result, carryout, zero and overflow into the rsp registers and set rsp_valid.
REQ-011 Latency from the accept edge to rsp_valid high SHALL be exactly SETTLE_CYCLES cycles.
REQ-012 While rsp_valid && !rsp_ready, all rsp_* outputs SHALL hold stable and no new request SHALL be accepted.
REQ-013 rsp_valid SHALL clear on the edge where rsp_ready is sampled high. The earliest next accept is the following edge, giving a minimum of SETTLE_CYCLES+2 cycles per operation.
REQ-014 The block SHALL not alter ALU semantics; command encodings are passed through unmodified.
REQ-015 A request that deasserts valid before being accepted SHALL be dropped without side effects.

Reset
REQ-016 When rst_n is low at a rising edge, the block SHALL set the following, regardless of the current state:
- state=IDLE, counter=0, last_grant=1 (requester 0 wins first);
- operand registers=0;
- rsp_valid=0, rsp_id=0, rsp_result=0, rsp_carryout=0, rsp_zero=0, rsp_overflow=0.
REQ-017 req0_ready and req1_ready SHALL be 0 while rst_n is low.
REQ-018 Reset asserted during SETTLE or RESP SHALL discard the in-flight operation; no response for it SHALL ever be presented.

Structure
REQ-019 The ALU command encodings (ADD=000, SUB=001, AND=100) and the FSM state encodings SHALL reside in the shared header alu_defs.v, used by this block and its bench.
REQ-020 The only sub-module SHALL be the existing 32-bit ALU, instantiated once. Arbitration, the counter and the FSM SHALL be local to alu_arbiter.

Verification
REQ-021 Single ADD: req0 only, a=0x00030D40, b=0x00004E20, cmd=000, SETTLE_CYCLES=2 -> rsp_valid exactly 2 cycles after the accept edge, with:
- rsp_result=0x00035B60, carryout=0, zero=0, overflow=0, rsp_id=0.
REQ-022 Zero flag: SUB with a=b=0x000186A0 -> rsp_result=0, zero=1, carryout=1, overflow=0.
REQ-023 Overflow: SUB with a=0x0BEBC200, b=0x88CA6C00 -> rsp_result=0x83215600, overflow=1, carryout=0, zero=0.
REQ-024 Contention: both valid from the first cycle after reset (req0 AND 3&5, req1 ADD 3+5), rsp_ready=1 ->
- first response rsp_id=0, result=0x00000001;
- then rsp_id=1, result=0x00000008;
- never two readys in one cycle.
REQ-025 Backpressure: rsp_ready=0 for 5 cycles after rsp_valid, with req1_valid=1 -> rsp_* outputs unchanged across all 5 cycles and req1_ready=0 throughout; req1 is accepted on the edge after the response handshake.
REQ-026 Reset mid-SETTLE: rst_n low for 1 edge during SETTLE ->
- rsp_valid stays 0;
- a subsequent simultaneous request from both requesters grants req0 first.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: ALU command encodings,
// arbiter FSM states and the settle counter width.
package alu_arbiter_pkg;

  typedef enum logic [2:0] {
    CMD_ADD = 3'b000,
    CMD_SUB = 3'b001,
    CMD_SLT = 3'b011,
    CMD_AND = 3'b100,
    CMD_OR  = 3'b101,
    CMD_XOR = 3'b110
  } alu_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RESP
  } state_e;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/alu_arbiter_alu.sv
// 32-bit combinational ALU shared by the arbiter; flags follow two's-complement
// add/subtract, with carryout meaning "no borrow" on subtraction.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [2:0]  command,
  output logic [31:0] result,
  output logic        carryout,
  output logic        zero,
  output logic        overflow
);

  logic        sub;
  logic [31:0] b_eff;
  logic [32:0] sum;
  logic        add_ovf;

  always_comb begin
    sub      = (command == CMD_SUB) || (command == CMD_SLT);
    b_eff    = sub ? ~operand_b : operand_b;
    sum      = {1'b0, operand_a} + {1'b0, b_eff} + {32'd0, sub};
    add_ovf  = (operand_a[31] == b_eff[31]) && (sum[31] != operand_a[31]);
    result   = '0;
    carryout = 1'b0;
    overflow = 1'b0;
    case (command)
      CMD_ADD, CMD_SUB: begin
        result   = sum[31:0];
        carryout = sum[32];
        overflow = add_ovf;
      end
      CMD_SLT: result = {31'd0, sum[31] ^ add_ovf};
      CMD_AND: result = operand_a & operand_b;
      CMD_OR:  result = operand_a | operand_b;
      CMD_XOR: result = operand_a ^ operand_b;
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; operands are held
// for SETTLE_CYCLES before the result is captured and offered as a response.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_cmd,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_cmd,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_carryout,
  output logic        rsp_zero,
  output logic        rsp_overflow
);

  state_e           state;
  logic [CNT_W-1:0] count;
  logic             last_grant;
  logic             grant;
  logic             accept;
  logic [31:0]      op_a;
  logic [31:0]      op_b;
  logic [2:0]       op_cmd;
  logic             op_id;
  logic [31:0]      alu_result;
  logic             alu_carryout;
  logic             alu_zero;
  logic             alu_overflow;

  // With both requesting, the one not served last wins; otherwise the lone requester.
  always_comb begin
    if (req0_valid && req1_valid) grant = ~last_grant;
    else                          grant = req1_valid;
  end

  assign req0_ready = (state == ST_IDLE) && rst_n && !grant;
  assign req1_ready = (state == ST_IDLE) && rst_n &&  grant;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  alu_arbiter_alu u_alu (
    .operand_a (op_a),
    .operand_b (op_b),
    .command   (op_cmd),
    .result    (alu_result),
    .carryout  (alu_carryout),
    .zero      (alu_zero),
    .overflow  (alu_overflow)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      count        <= '0;
      last_grant   <= 1'b1;
      op_a         <= '0;
      op_b         <= '0;
      op_cmd       <= '0;
      op_id        <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_carryout <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_a       <= grant ? req1_a   : req0_a;
            op_b       <= grant ? req1_b   : req0_b;
            op_cmd     <= grant ? req1_cmd : req0_cmd;
            op_id      <= grant;
            last_grant <= grant;
            count      <= CNT_W'(SETTLE_CYCLES - 1);
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (count == '0) begin
            rsp_valid    <= 1'b1;
            rsp_id       <= op_id;
            rsp_result   <= alu_result;
            rsp_carryout <= alu_carryout;
            rsp_zero     <= alu_zero;
            rsp_overflow <= alu_overflow;
            state        <= ST_RESP;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: hand-computed ALU results, latency, round-robin
// ordering, backpressure hold and reset during an in-flight operation.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_cmd, req1_cmd;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_carryout, rsp_zero, rsp_overflow;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.SETTLE_CYCLES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req0_cmd     (req0_cmd),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req1_cmd     (req1_cmd),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_carryout (rsp_carryout),
    .rsp_zero     (rsp_zero),
    .rsp_overflow (rsp_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Both readys high in the same cycle is never allowed.
  always @(negedge clk) check("onehot_ready", 32'(req0_ready & req1_ready), 32'd0);

  task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] cmd);
    bit ok;
    ok = 1'b0;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cmd = cmd; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cmd = cmd; end
    #1;
    for (int i = 0; i < 50; i++) begin
      if (id ? req1_ready : req0_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("accept_timeout", 32'(ok), 32'd1);
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_clear", 32'(rsp_valid), 32'd0);
  endtask

  task automatic check_rsp(input string tag, input bit id, input logic [31:0] res,
                           input bit c, input bit z, input bit v);
    check({tag, "_id"},    32'(rsp_id),       32'(id));
    check({tag, "_res"},   rsp_result,        res);
    check({tag, "_carry"}, 32'(rsp_carryout), 32'(c));
    check({tag, "_zero"},  32'(rsp_zero),     32'(z));
    check({tag, "_ovf"},   32'(rsp_overflow), 32'(v));
  endtask

  int          n;
  int          nr;
  bit          r0, r1;
  logic        ids [2];
  logic [31:0] res [2];

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cmd = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cmd = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_ready1", 32'(req1_ready), 32'd0);
    check("rst_valid",  32'(rsp_valid),  32'd0);
    check("rst_result", rsp_result,      32'd0);
    check("rst_id",     32'(rsp_id),     32'd0);

    // Contention straight out of reset: req0 wins first
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd5; req0_cmd = CMD_AND;
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd5; req1_cmd = CMD_ADD;
    rsp_ready = 1'b1;
    #1;
    nr = 0;
    for (int c = 0; c < 60 && nr < 2; c++) begin
      r0 = req0_valid && req0_ready;
      r1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (r0) req0_valid = 1'b0;
      if (r1) req1_valid = 1'b0;
      if (rsp_valid) begin ids[nr] = rsp_id; res[nr] = rsp_result; nr++; end
    end
    check("cont_count", 32'(nr),     32'd2);
    check("cont_id0",   32'(ids[0]), 32'd0);
    check("cont_res0",  res[0],      32'h0000_0001);
    check("cont_id1",   32'(ids[1]), 32'd1);
    check("cont_res1",  res[1],      32'h0000_0008);
    handshake();

    // Single ADD with latency check
    issue(1'b0, 32'h0003_0D40, 32'h0000_4E20, CMD_ADD);
    wait_rsp(n);
    check("add_latency", 32'(n), 32'd2);
    check_rsp("add", 1'b0, 32'h0003_5B60, 1'b0, 1'b0, 1'b0);
    handshake();

    // Zero flag from SUB of equal operands
    issue(1'b1, 32'h0001_86A0, 32'h0001_86A0, CMD_SUB);
    wait_rsp(n);
    check("zero_latency", 32'(n), 32'd2);
    check_rsp("zero", 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    handshake();

    // Signed overflow from SUB
    issue(1'b0, 32'h0BEB_C200, 32'h88CA_6C00, CMD_SUB);
    wait_rsp(n);
    check_rsp("ovf", 1'b0, 32'h8321_5600, 1'b0, 1'b0, 1'b1);
    handshake();

    // Backpressure: response held, req1 blocked until after the handshake
    issue(1'b0, 32'd7, 32'd9, CMD_ADD);
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_cmd = CMD_ADD;
    wait_rsp(n);
    check("bp_latency", 32'(n), 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid",  32'(rsp_valid),  32'd1);
      check("bp_result", rsp_result,      32'd16);
      check("bp_id",     32'(rsp_id),     32'd0);
      check("bp_ready1", 32'(req1_ready), 32'd0);
    end
    handshake();
    check("bp_ready1_after", 32'(req1_ready), 32'd1);
    @(posedge clk); #1;
    check("bp_accepted", 32'(req1_ready), 32'd0);
    req1_valid = 1'b0;
    wait_rsp(n);
    check("bp2_latency", 32'(n), 32'd2);
    check_rsp("bp2", 1'b1, 32'd2, 1'b0, 1'b0, 1'b0);
    handshake();

    // Reset during SETTLE discards the operation and restores req0 priority
    issue(1'b0, 32'd5, 32'd5, CMD_ADD);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    end
    req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd4; req0_cmd = CMD_SUB;
    req1_valid = 1'b1; req1_a = 32'd6; req1_b = 32'd3; req1_cmd = CMD_AND;
    #1;
    check("mid_rst_ready0", 32'(req0_ready), 32'd1);
    check("mid_rst_ready1", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wait_rsp(n);
    check("mid_rst_latency", 32'(n), 32'd2);
    check_rsp("mid_rst", 1'b0, 32'd5, 1'b1, 1'b0, 1'b0);
    handshake();
    req1_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      check("dropped_req", 32'(rsp_valid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
